// File: rtl/atrover_io_pkg.sv
// Shared IO-window definitions for the atrover dBus peripherals.
// Word offsets, UART register bit positions and the UART TX state encoding.
package atrover_io_pkg;

  localparam logic [1:0] UART_DATA   = 2'd0;
  localparam logic [1:0] UART_STATUS = 2'd1;
  localparam logic [1:0] UART_CTRL   = 2'd2;
  localparam logic [1:0] UART_RSVD   = 2'd3;

  localparam int unsigned ST_TX_FULL      = 0;
  localparam int unsigned ST_TX_EMPTY     = 1;
  localparam int unsigned ST_RX_EMPTY     = 2;
  localparam int unsigned ST_RX_FULL      = 3;
  localparam int unsigned ST_RX_OVERRUN   = 4;
  localparam int unsigned ST_TX_DROP      = 5;
  localparam int unsigned ST_TX_COUNT_LSB = 8;
  localparam int unsigned ST_RX_COUNT_LSB = 16;

  localparam int unsigned CTRL_RX_IE     = 0;
  localparam int unsigned CTRL_TXE_IE    = 1;
  localparam int unsigned CTRL_CLR_STICKY = 2;
  localparam int unsigned CTRL_FLUSH     = 3;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SEND  = 2'd1,
    BUSY  = 2'd2,
    DRAIN = 2'd3
  } uart_tx_state_e;

endpackage

// File: rtl/sync_fifo.sv
// First-word-fall-through synchronous FIFO with synchronous flush.
// A push into a full FIFO is accepted when a pop happens on the same edge.
module sync_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 16
) (
  input  logic                         clk,
  input  logic                         resetn,
  input  logic                         flush,
  input  logic                         push,
  input  logic                         pop,
  input  logic [WIDTH-1:0]             din,
  output logic [WIDTH-1:0]             dout,
  output logic                         full,
  output logic                         empty,
  output logic [$clog2(DEPTH+1)-1:0]   count
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH+1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wptr_q, wptr_d;
  logic [AW-1:0]    rptr_q, rptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             do_push, do_pop;

  assign full    = (count_q == CW'(DEPTH));
  assign empty   = (count_q == '0);
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign dout    = mem_q[rptr_q];
  assign count   = count_q;

  always_comb begin
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    count_d = count_q;
    if (flush) begin
      wptr_d  = '0;
      rptr_d  = '0;
      count_d = '0;
    end else begin
      if (do_push) wptr_d = wptr_q + AW'(1);
      if (do_pop)  rptr_d = rptr_q + AW'(1);
      if (do_push && !do_pop)      count_d = count_q + CW'(1);
      else if (!do_push && do_pop) count_d = count_q - CW'(1);
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !flush) mem_q[wptr_q] <= din;
  end

endmodule

// File: rtl/uart_fifo_bridge.sv
// Memory-mapped UART front end: TX/RX FIFOs, STATUS/CTRL registers and an
// interrupt line between the dBus IO decoder and uart_lite.
module uart_fifo_bridge
  import atrover_io_pkg::*;
#(
  parameter int unsigned RISCV_WL  = 32,
  parameter int unsigned DATA_BITS = 8,
  parameter int unsigned TX_DEPTH  = 16,
  parameter int unsigned RX_DEPTH  = 16
) (
  input  logic                 clk,
  input  logic                 resetn,
  input  logic                 io_valid,
  input  logic                 io_wr,
  input  logic [1:0]           io_addr,
  input  logic [RISCV_WL-1:0]  io_wdata,
  output logic [RISCV_WL-1:0]  io_rdata,
  output logic                 io_irq,
  input  logic                 tx_rdy,
  output logic                 tx_vld,
  output logic [DATA_BITS-1:0] tx_data,
  input  logic                 rx_valid,
  input  logic [DATA_BITS-1:0] rx_data
);

  localparam int unsigned TXCW = $clog2(TX_DEPTH+1);
  localparam int unsigned RXCW = $clog2(RX_DEPTH+1);

  logic                 wr_data, wr_ctrl, rd_access, rd_data;
  logic                 flush, clr_sticky;
  logic                 tx_full, tx_empty, tx_pop;
  logic                 rx_full, rx_empty, rx_pop;
  logic [DATA_BITS-1:0] tx_dout, rx_dout;
  logic [TXCW-1:0]      tx_count;
  logic [RXCW-1:0]      rx_count;
  logic                 tx_idle;

  uart_tx_state_e       state_q, state_d;
  logic [DATA_BITS-1:0] tx_data_q, tx_data_d;
  logic [RISCV_WL-1:0]  io_rdata_q, io_rdata_d;
  logic [RISCV_WL-1:0]  status_w;
  logic                 rx_ie_q, rx_ie_d, txe_ie_q, txe_ie_d;
  logic                 rx_overrun_q, rx_overrun_d, tx_drop_q, tx_drop_d;
  logic                 unused_wdata;

  assign unused_wdata = ^io_wdata;

  assign rd_access  = io_valid & ~io_wr;
  assign wr_data    = io_valid & io_wr & (io_addr == UART_DATA);
  assign wr_ctrl    = io_valid & io_wr & (io_addr == UART_CTRL);
  assign rd_data    = rd_access & (io_addr == UART_DATA);
  assign flush      = wr_ctrl & io_wdata[CTRL_FLUSH];
  assign clr_sticky = wr_ctrl & io_wdata[CTRL_CLR_STICKY];

  assign tx_idle = (state_q == IDLE);
  assign tx_pop  = tx_idle & ~tx_empty & tx_rdy;
  assign rx_pop  = rd_data & ~rx_empty;

  sync_fifo #(.WIDTH(DATA_BITS), .DEPTH(TX_DEPTH)) u_tx_fifo (
    .clk    (clk),
    .resetn (resetn),
    .flush  (flush),
    .push   (wr_data),
    .pop    (tx_pop),
    .din    (io_wdata[DATA_BITS-1:0]),
    .dout   (tx_dout),
    .full   (tx_full),
    .empty  (tx_empty),
    .count  (tx_count)
  );

  sync_fifo #(.WIDTH(DATA_BITS), .DEPTH(RX_DEPTH)) u_rx_fifo (
    .clk    (clk),
    .resetn (resetn),
    .flush  (flush),
    .push   (rx_valid),
    .pop    (rx_pop),
    .din    (rx_data),
    .dout   (rx_dout),
    .full   (rx_full),
    .empty  (rx_empty),
    .count  (rx_count)
  );

  // A drop/overrun only counts when the byte was refused for lack of room,
  // not when a flush swallowed it.
  always_comb begin
    rx_ie_d      = rx_ie_q;
    txe_ie_d     = txe_ie_q;
    tx_drop_d    = tx_drop_q;
    rx_overrun_d = rx_overrun_q;
    if (wr_ctrl) begin
      rx_ie_d  = io_wdata[CTRL_RX_IE];
      txe_ie_d = io_wdata[CTRL_TXE_IE];
    end
    if (clr_sticky) begin
      tx_drop_d    = 1'b0;
      rx_overrun_d = 1'b0;
    end
    if (wr_data && tx_full && !tx_pop && !flush)  tx_drop_d    = 1'b1;
    if (rx_valid && rx_full && !rx_pop && !flush) rx_overrun_d = 1'b1;
  end

  always_comb begin
    state_d   = state_q;
    tx_data_d = tx_data_q;
    unique case (state_q)
      IDLE: if (tx_pop) begin
        tx_data_d = tx_dout;
        state_d   = SEND;
      end
      SEND:  state_d = BUSY;
      BUSY:  if (!tx_rdy) state_d = DRAIN;
      DRAIN: if (tx_rdy)  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    status_w                                  = '0;
    status_w[ST_TX_FULL]                      = tx_full;
    status_w[ST_TX_EMPTY]                     = tx_empty;
    status_w[ST_RX_EMPTY]                     = rx_empty;
    status_w[ST_RX_FULL]                      = rx_full;
    status_w[ST_RX_OVERRUN]                   = rx_overrun_q;
    status_w[ST_TX_DROP]                      = tx_drop_q;
    status_w[ST_TX_COUNT_LSB +: 8]            = 8'(tx_count);
    status_w[ST_RX_COUNT_LSB +: 8]            = 8'(rx_count);
  end

  always_comb begin
    io_rdata_d = io_rdata_q;
    if (rd_access) begin
      io_rdata_d = '0;
      unique case (io_addr)
        UART_DATA: if (!rx_empty) begin
          io_rdata_d[RISCV_WL-1]    = 1'b1;
          io_rdata_d[DATA_BITS-1:0] = rx_dout;
        end
        UART_STATUS: io_rdata_d = status_w;
        UART_CTRL: begin
          io_rdata_d[CTRL_RX_IE]  = rx_ie_q;
          io_rdata_d[CTRL_TXE_IE] = txe_ie_q;
        end
        default: io_rdata_d = '0;
      endcase
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q      <= IDLE;
      tx_data_q    <= '0;
      io_rdata_q   <= '0;
      rx_ie_q      <= 1'b0;
      txe_ie_q     <= 1'b0;
      tx_drop_q    <= 1'b0;
      rx_overrun_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      tx_data_q    <= tx_data_d;
      io_rdata_q   <= io_rdata_d;
      rx_ie_q      <= rx_ie_d;
      txe_ie_q     <= txe_ie_d;
      tx_drop_q    <= tx_drop_d;
      rx_overrun_q <= rx_overrun_d;
    end
  end

  assign io_rdata = io_rdata_q;
  assign tx_data  = tx_data_q;
  assign tx_vld   = (state_q == SEND);
  assign io_irq   = (rx_ie_q & ~rx_empty) | (txe_ie_q & tx_empty & tx_idle);

endmodule

// File: tb/tb_uart_fifo_bridge.sv
// Directed bench for uart_fifo_bridge with a small uart_lite transmitter model.
// Inputs are driven and outputs sampled on the falling clock edge.
module tb_uart_fifo_bridge;

  localparam logic [1:0] A_DATA   = 2'd0;
  localparam logic [1:0] A_STATUS = 2'd1;
  localparam logic [1:0] A_CTRL   = 2'd2;
  localparam logic [1:0] A_RSVD   = 2'd3;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        io_valid = 1'b0;
  logic        io_wr = 1'b0;
  logic [1:0]  io_addr = 2'd0;
  logic [31:0] io_wdata = '0;
  logic [31:0] io_rdata;
  logic        io_irq;
  logic        tx_rdy;
  logic        tx_vld;
  logic [7:0]  tx_data;
  logic        rx_valid = 1'b0;
  logic [7:0]  rx_data = '0;

  logic        tx_hold = 1'b0;
  int          busy_cnt = 0;
  int          cyc = 0;
  logic [7:0]  launch_q[$];
  int          launch_cyc[$];
  int          n_cmp = 0;
  int          n_err = 0;

  uart_fifo_bridge #(
    .RISCV_WL  (32),
    .DATA_BITS (8),
    .TX_DEPTH  (16),
    .RX_DEPTH  (16)
  ) dut (
    .clk      (clk),
    .resetn   (resetn),
    .io_valid (io_valid),
    .io_wr    (io_wr),
    .io_addr  (io_addr),
    .io_wdata (io_wdata),
    .io_rdata (io_rdata),
    .io_irq   (io_irq),
    .tx_rdy   (tx_rdy),
    .tx_vld   (tx_vld),
    .tx_data  (tx_data),
    .rx_valid (rx_valid),
    .rx_data  (rx_data)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Transmitter model: goes busy for 6 cycles after each launch.
  always @(negedge clk) begin
    if (tx_vld) begin
      launch_q.push_back(tx_data);
      launch_cyc.push_back(cyc);
      busy_cnt <= 6;
    end else if (busy_cnt > 0) begin
      busy_cnt <= busy_cnt - 1;
    end
  end
  assign tx_rdy = ~tx_hold & (busy_cnt == 0);

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic cpu_write(input logic [1:0] a, input logic [31:0] d);
    io_valid = 1'b1; io_wr = 1'b1; io_addr = a; io_wdata = d;
    @(negedge clk);
    io_valid = 1'b0; io_wr = 1'b0;
  endtask

  task automatic cpu_read(input logic [1:0] a, output logic [31:0] d);
    io_valid = 1'b1; io_wr = 1'b0; io_addr = a;
    @(negedge clk);
    io_valid = 1'b0;
    d = io_rdata;
  endtask

  task automatic rx_strobe(input logic [7:0] b);
    rx_valid = 1'b1; rx_data = b;
    @(negedge clk);
    rx_valid = 1'b0;
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [31:0] rd;
    int          min_gap;

    repeat (3) @(negedge clk);
    check_eq("rst_rdata", io_rdata, 32'h0);
    check_eq("rst_irq", io_irq, 32'h0);
    check_eq("rst_tx_vld", tx_vld, 32'h0);
    check_eq("rst_tx_data", tx_data, 32'h0);
    resetn = 1'b1;
    @(negedge clk);
    cpu_read(A_STATUS, rd); check_eq("rst_status", rd, 32'h6);
    cpu_read(A_CTRL, rd);   check_eq("rst_ctrl", rd, 32'h0);

    cpu_write(A_STATUS, 32'hFFFF_FFFF);
    cpu_write(A_RSVD, 32'hFFFF_FFFF);
    cpu_read(A_STATUS, rd); check_eq("status_ro", rd, 32'h6);
    cpu_read(A_RSVD, rd);   check_eq("rsvd_zero", rd, 32'h0);

    // single byte: launch two cycles after the push
    launch_q.delete(); launch_cyc.delete();
    cpu_write(A_DATA, 32'h41);
    check_eq("tx1_vld_early", tx_vld, 32'h0);
    @(negedge clk);
    check_eq("tx1_vld", tx_vld, 32'h1);
    check_eq("tx1_data", tx_data, 32'h41);
    @(negedge clk);
    check_eq("tx1_vld_pulse", tx_vld, 32'h0);
    cpu_read(A_STATUS, rd); check_eq("tx1_status", rd, 32'h6);
    repeat (12) @(negedge clk);
    check_eq("tx1_launches", launch_q.size(), 32'd1);

    // TX overflow with the transmitter held busy
    tx_hold = 1'b1;
    launch_q.delete(); launch_cyc.delete();
    for (int i = 0; i < 17; i++) cpu_write(A_DATA, 32'(i));
    cpu_read(A_STATUS, rd); check_eq("ovf_status", rd, 32'h1025);
    tx_hold = 1'b0;
    for (int i = 0; i < 400 && launch_q.size() < 16; i++) @(negedge clk);
    check_eq("ovf_launch_cnt", launch_q.size(), 32'd16);
    for (int i = 0; i < 16 && i < launch_q.size(); i++)
      check_eq($sformatf("ovf_byte%0d", i), launch_q[i], 32'(i));
    min_gap = 1000;
    for (int i = 1; i < launch_cyc.size(); i++)
      if (launch_cyc[i] - launch_cyc[i-1] < min_gap) min_gap = launch_cyc[i] - launch_cyc[i-1];
    check_eq("ovf_gap_ge4", 32'(min_gap >= 4), 32'h1);
    cpu_read(A_STATUS, rd); check_eq("ovf_drained", rd, 32'h26);
    cpu_write(A_CTRL, 32'h4);
    cpu_read(A_STATUS, rd); check_eq("ovf_clr", rd, 32'h6);
    repeat (12) @(negedge clk);

    // RX overrun
    for (int i = 0; i < 17; i++) rx_strobe(8'(8'h80 + i));
    cpu_read(A_STATUS, rd); check_eq("rxo_status", rd, 32'h0010_001A);
    for (int i = 0; i < 16; i++) begin
      cpu_read(A_DATA, rd);
      check_eq($sformatf("rxo_read%0d", i), rd, 32'h8000_0080 + 32'(i));
    end
    cpu_read(A_DATA, rd);   check_eq("rxo_empty_read", rd, 32'h0);
    cpu_read(A_STATUS, rd); check_eq("rxo_status2", rd, 32'h16);
    cpu_write(A_CTRL, 32'h4);
    cpu_read(A_STATUS, rd); check_eq("rxo_clr", rd, 32'h6);

    // simultaneous pop and push with RX full
    for (int i = 0; i < 16; i++) rx_strobe(8'(8'h10 + i));
    rx_valid = 1'b1; rx_data = 8'hAA;
    io_valid = 1'b1; io_wr = 1'b0; io_addr = A_DATA;
    @(negedge clk);
    rx_valid = 1'b0; io_valid = 1'b0;
    check_eq("sim_read", io_rdata, 32'h8000_0010);
    cpu_read(A_STATUS, rd); check_eq("sim_status", rd, 32'h0010_000A);
    for (int i = 1; i < 16; i++) begin
      cpu_read(A_DATA, rd);
      check_eq($sformatf("sim_read%0d", i), rd, 32'h8000_0010 + 32'(i));
    end
    cpu_read(A_DATA, rd);   check_eq("sim_last", rd, 32'h8000_00AA);
    cpu_read(A_STATUS, rd); check_eq("sim_status2", rd, 32'h6);

    // interrupt
    cpu_write(A_CTRL, 32'h1);
    cpu_read(A_CTRL, rd);   check_eq("irq_ctrl_rx", rd, 32'h1);
    check_eq("irq_idle", io_irq, 32'h0);
    rx_strobe(8'h55);
    check_eq("irq_rx", io_irq, 32'h1);
    cpu_read(A_DATA, rd);   check_eq("irq_data", rd, 32'h8000_0055);
    check_eq("irq_rx_clr", io_irq, 32'h0);
    cpu_write(A_CTRL, 32'hE);
    check_eq("irq_txe", io_irq, 32'h1);
    cpu_read(A_CTRL, rd);   check_eq("irq_ctrl_txe", rd, 32'h2);
    cpu_write(A_CTRL, 32'h0);
    check_eq("irq_off", io_irq, 32'h0);

    // flush while the first byte is in flight
    launch_q.delete(); launch_cyc.delete();
    for (int i = 0; i < 5; i++) cpu_write(A_DATA, 32'hA0 + 32'(i));
    check_eq("fl_inflight", launch_q.size(), 32'd1);
    cpu_write(A_CTRL, 32'h8);
    cpu_read(A_STATUS, rd); check_eq("fl_status", rd, 32'h6);
    repeat (40) @(negedge clk);
    check_eq("fl_launch_cnt", launch_q.size(), 32'd1);
    if (launch_q.size() > 0) check_eq("fl_byte", launch_q[0], 32'hA0);
    check_eq("fl_tx_data", tx_data, 32'hA0);

    // asynchronous reset mid-frame
    cpu_write(A_CTRL, 32'h2);
    cpu_read(A_STATUS, rd); check_eq("ar_pre_status", rd, 32'h6);
    cpu_write(A_DATA, 32'h5A);
    for (int i = 0; i < 20 && !tx_vld; i++) @(negedge clk);
    check_eq("ar_pre_vld", tx_vld, 32'h1);
    #2 resetn = 1'b0;
    #1;
    check_eq("ar_tx_vld", tx_vld, 32'h0);
    check_eq("ar_tx_data", tx_data, 32'h0);
    check_eq("ar_rdata", io_rdata, 32'h0);
    check_eq("ar_irq", io_irq, 32'h0);
    @(negedge clk);
    resetn = 1'b1;
    @(negedge clk);
    cpu_read(A_STATUS, rd); check_eq("ar_status", rd, 32'h6);
    cpu_read(A_CTRL, rd);   check_eq("ar_ctrl", rd, 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
